// File: rtl/ysyx_22041207_fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   fetch_state_e : fetch FSM states (idle / request / wait for response)
//   FETCH_BYTES   : size of every fetch request in bytes
//   ENTRY_W       : width of a FIFO entry ({pc, inst})
package ysyx_22041207_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

  localparam logic [7:0]  FETCH_BYTES = 8'd4;
  localparam int unsigned ENTRY_W     = 96;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_22041207_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries. The head is kept in its
// own register so the consumer sees a registered output.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : drop all entries (wins over push and pop)
//   push_i   : write data_i at the tail
//   pop_i    : remove the head entry (ignored when empty)
//   data_i   : entry to push
//   count_o  : number of valid entries
//   head_o   : oldest entry, zero when empty after reset/clear/pop-to-empty
module ysyx_22041207_fetch_fifo
  import ysyx_22041207_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, rptr_nx;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_eff, pop_eff;

  assign rptr_nx  = rptr_q + 1'b1;
  assign pop_eff  = pop_i && !clear_i && (count_q != '0);
  assign push_eff = push_i && !clear_i && ((count_q != DepthC) || pop_eff);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    head_d  = head_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      head_d  = '0;
    end else begin
      if (push_eff) wptr_d = wptr_q + 1'b1;
      if (pop_eff)  rptr_d = rptr_nx;
      count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
      if (pop_eff) begin
        // Next head comes from storage, from the entry being pushed, or is empty.
        if (count_q > CntW'(1)) head_d = mem_q[rptr_nx];
        else if (push_eff)      head_d = data_i;
        else                    head_d = '0;
      end else if (push_eff && (count_q == '0)) begin
        head_d = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/ysyx_22041207_fetch_queue.sv
// Instruction fetch front end: issues 4-byte reads on the shared read channel,
// buffers returned words with their PCs and presents them to IF/ID.
//   clk, rst          : clock, synchronous active-high reset
//   redirect_valid/pc : flush and restart fetch at redirect_pc (bits [1:0] dropped)
//   stall             : downstream not accepting
//   inst_valid/inst/inst_pc : FIFO head
//   rd_valid_o/rd_ready_i/rd_addr_o/rd_size_o : read request channel
//   rd_data_i/rd_data_valid_i/rd_data_ready_o : read response channel
module ysyx_22041207_fetch_queue
  import ysyx_22041207_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [63:0] rd_addr_o,
  output logic [7:0]  rd_size_o,
  input  logic [63:0] rd_data_i,
  input  logic        rd_data_valid_i,
  output logic        rd_data_ready_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      req_addr_q, req_addr_d;
  logic             discard_q, discard_d;
  logic [CntW-1:0]  fifo_count, count_after;
  logic             resp_fire, push, pop;
  logic [31:0]      word;
  fetch_entry_t     push_entry, head_entry;

  assign resp_fire = (state_q == StWait) && rd_data_valid_i;
  assign push      = resp_fire && !discard_q && !redirect_valid;
  assign pop       = inst_valid && !stall && !redirect_valid;
  assign word      = req_addr_q[2] ? rd_data_i[63:32] : rd_data_i[31:0];
  assign push_entry = '{pc: req_addr_q, inst: word};
  assign count_after = fifo_count + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    if (push) fetch_pc_d = fetch_pc_q + 64'd4;
    if (redirect_valid) fetch_pc_d = {redirect_pc[63:2], 2'b00};
    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && (fifo_count < DepthC)) begin
          state_d    = StReq;
          req_addr_d = fetch_pc_q;
        end
      end
      StReq: begin
        // The request already on the bus cannot be withdrawn; mark it stale.
        if (redirect_valid) discard_d = 1'b1;
        if (rd_ready_i)     state_d   = StWait;
      end
      StWait: begin
        if (resp_fire) begin
          discard_d = 1'b0;
          // A redirect empties the FIFO, so a slot is always free then.
          if (redirect_valid || (count_after < DepthC)) begin
            state_d    = StReq;
            req_addr_d = fetch_pc_d;
          end else begin
            state_d = StIdle;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  ysyx_22041207_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .count_o (fifo_count),
    .head_o  (head_entry)
  );

  assign inst_valid      = (fifo_count != '0);
  assign inst            = head_entry.inst;
  assign inst_pc         = head_entry.pc;
  assign rd_valid_o      = (state_q == StReq);
  assign rd_addr_o       = req_addr_q;
  assign rd_size_o       = FETCH_BYTES;
  assign rd_data_ready_o = (state_q == StWait);

endmodule
